// File: rtl/vga_stream_out.sv
// vga_stream_out
// Programmable-timing VGA output stage. Free-running h/v raster counters
// define the frame; a pixel stream with a start-of-frame marker is locked
// to raster position (0,0) and its beats are painted into the active area.
// Every DAC-facing output is registered one clock after the raster position
// that produced it.
//
// Ports
//   clk_clk      pixel clock (only clock)
//   reset_reset  asynchronous, active-high reset
//   enable       raster enable; low holds counters at 0, SEEK, idle outputs
//   pix_data     {R,G,B} stream payload, R in the MSBs
//   pix_valid    stream beat valid
//   pix_sof      beat is the first pixel of a frame
//   pix_ready    combinational ready back to the stream source
//   vga_HS/VS    syncs, asserted level set by HS_POL / VS_POL
//   vga_BLANK    high in the visible area (DAC BLANK_n)
//   vga_SYNC     tied low
//   vga_R/G/B    colour
//   frame_start  one-cycle pulse on the output for raster (0,0)
//   underflow    sticky: stream starved on a visible pixel while locked
//
// Handshake: a beat transfers on a rising edge where pix_valid && pix_ready.
// pix_ready may depend on pix_valid/pix_sof but the source must hold a beat
// stable until it transfers.
module vga_stream_out #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int COLOR_W  = 4,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset,
   input  logic                 enable,
   input  logic [3*COLOR_W-1:0] pix_data,
   input  logic                 pix_valid,
   input  logic                 pix_sof,
   output logic                 pix_ready,
   output logic                 vga_HS,
   output logic                 vga_VS,
   output logic                 vga_BLANK,
   output logic                 vga_SYNC,
   output logic [COLOR_W-1:0]   vga_R,
   output logic [COLOR_W-1:0]   vga_G,
   output logic [COLOR_W-1:0]   vga_B,
   output logic                 frame_start,
   output logic                 underflow
);

   localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW       = $clog2(H_TOT);
   localparam int VW       = $clog2(V_TOT);
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   typedef enum logic {SEEK = 1'b0, LOCKED = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [HW-1:0]        h;
   logic [VW-1:0]        v;
   logic                 bad_q, bad_d;
   logic                 starve;
   logic [3*COLOR_W-1:0] rgb_d;
   logic                 active, origin, h_last, frame_end, hs_on, vs_on;

   assign active    = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
   assign origin    = (h == '0) && (v == '0);
   assign h_last    = (h == HW'(H_TOT - 1));
   assign frame_end = h_last && (v == VW'(V_TOT - 1));
   assign hs_on     = (int'(h) >= HS_START) && (int'(h) < HS_END);
   assign vs_on     = (int'(v) >= VS_START) && (int'(v) < VS_END);
   assign vga_SYNC  = 1'b0;

   // Raster counters; held at the origin while disabled so the first
   // enabled cycle is position (0,0).
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         h <= '0;
         v <= '0;
      end else if (!enable) begin
         h <= '0;
         v <= '0;
      end else if (h_last) begin
         h <= '0;
         v <= (v == VW'(V_TOT - 1)) ? '0 : v + VW'(1);
      end else begin
         h <= h + HW'(1);
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q <= SEEK;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bad_q   <= bad_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bad_d     = bad_q;
      pix_ready = 1'b0;
      rgb_d     = '0;
      starve    = 1'b0;
      if (!enable) begin
         state_d = SEEK;
         bad_d   = 1'b0;
      end else begin
         case (state_q)
            SEEK: begin
               // Drain non-SOF beats; a SOF beat waits for the origin.
               pix_ready = pix_valid && (!pix_sof || origin);
               if (origin && pix_valid && pix_sof) begin
                  state_d = LOCKED;
                  bad_d   = 1'b0;
                  rgb_d   = pix_data;
               end
            end
            LOCKED: begin
               // A misplaced SOF is held at the head of the stream so it can
               // become pixel (0,0) after resynchronising.
               pix_ready = active && !(pix_valid && pix_sof && !origin);
               if (active) begin
                  if (!pix_valid) begin
                     starve = 1'b1;
                     bad_d  = 1'b1;
                  end else if (pix_sof && !origin) begin
                     bad_d = 1'b1;
                  end else begin
                     rgb_d = pix_data;
                  end
               end
               // A damaged frame still runs to completion before resync.
               if (frame_end && bad_q) begin
                  state_d = SEEK;
                  bad_d   = 1'b0;
               end
            end
            default: begin
               state_d = SEEK;
               bad_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         vga_HS      <= ~HS_POL;
         vga_VS      <= ~VS_POL;
         vga_BLANK   <= 1'b0;
         vga_R       <= '0;
         vga_G       <= '0;
         vga_B       <= '0;
         frame_start <= 1'b0;
      end else if (!enable) begin
         vga_HS      <= ~HS_POL;
         vga_VS      <= ~VS_POL;
         vga_BLANK   <= 1'b0;
         vga_R       <= '0;
         vga_G       <= '0;
         vga_B       <= '0;
         frame_start <= 1'b0;
      end else begin
         vga_HS      <= hs_on ? HS_POL : ~HS_POL;
         vga_VS      <= vs_on ? VS_POL : ~VS_POL;
         vga_BLANK   <= active;
         vga_R       <= rgb_d[3*COLOR_W-1 -: COLOR_W];
         vga_G       <= rgb_d[2*COLOR_W-1 -: COLOR_W];
         vga_B       <= rgb_d[COLOR_W-1:0];
         frame_start <= origin;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         underflow <= 1'b0;
      end else if (starve) begin
         underflow <= 1'b1;
      end
   end

endmodule
